mux_key: RTL and testbench

Parameterised lookup multiplexer: compares an input key against a packed table of (key, data) pairs and drives the data of the matching entry, or a default of zero when no entry matches. It is the generic selector used by the decode and branch-condition logic (e.g. Branch → {PCAsrc, PCBsrc}). The primary output is purely combinational. A registered copy of the result is also provided on the shared clock for pipelined users.

---
 rtl/mux_key.sv | 64 ++++++
 tb/tb_mux_key.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/mux_key.sv
// Priority key lookup: selects the data of the first table entry whose key
// matches, zero when none does, plus a registered copy of out/hit.
module mux_key #(
    parameter int NR_KEY   = 2,
    parameter int KEY_LEN  = 1,
    parameter int DATA_LEN = 1
) (
    input  logic                                 clk,
    input  logic                                 rst_n,
    input  logic [KEY_LEN-1:0]                   key,
    input  logic [NR_KEY*(KEY_LEN+DATA_LEN)-1:0] lut,
    output logic [DATA_LEN-1:0]                  out,
    output logic                                 hit,
    output logic [DATA_LEN-1:0]                  out_q,
    output logic                                 hit_q
);

    localparam int W = KEY_LEN + DATA_LEN;

    logic [KEY_LEN-1:0]  entry_key  [NR_KEY];
    logic [DATA_LEN-1:0] entry_data [NR_KEY];
    logic [NR_KEY-1:0]   match;

    // Entry 0 sits in the MSBs, so it is the first pair written in a concatenation.
    generate
        for (genvar gi = 0; gi < NR_KEY; gi++) begin : g_entry
            assign entry_key[gi]  = lut[(NR_KEY-gi)*W-1 -: KEY_LEN];
            assign entry_data[gi] = lut[(NR_KEY-gi)*W-KEY_LEN-1 -: DATA_LEN];
            assign match[gi]      = (entry_key[gi] == key);
        end
    endgenerate

    logic [DATA_LEN-1:0] out_next;

    // Scan from the last entry down so the lowest matching index is written last.
    always_comb begin
        out_next = '0;
        for (int i = NR_KEY - 1; i >= 0; i--) begin
            if (match[i]) begin
                out_next = entry_data[i];
            end
        end
    end

    assign out = out_next;
    assign hit = |match;

    logic [DATA_LEN-1:0] out_reg;
    logic                hit_reg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_reg <= '0;
            hit_reg <= 1'b0;
        end else begin
            out_reg <= out_next;
            hit_reg <= hit;
        end
    end

    assign out_q = out_reg;
    assign hit_q = hit_reg;

endmodule

// File: tb/tb_mux_key.sv
// Self-checking bench for mux_key: three table shapes, live data, duplicate
// keys, the registered path and asynchronous reset.
module tb_mux_key;

    logic clk;
    logic rst_n;

    // 7-entry decode table with live zc/lc data.
    logic [2:0]  key7;
    logic [1:0]  zc;
    logic [1:0]  lc;
    logic [34:0] lut7;
    logic [1:0]  out7;
    logic        hit7;
    logic [1:0]  out_q7;
    logic        hit_q7;

    assign lut7 = {3'b000, 2'b00, 3'b001, 2'b10, 3'b010, 2'b11,
                   3'b100, zc, 3'b101, zc, 3'b110, lc, 3'b111, lc};

    // Duplicate-key table.
    logic [1:0]  key3;
    logic [11:0] lut3;
    logic [1:0]  out3;
    logic        hit3;
    logic [1:0]  out_q3;
    logic        hit_q3;

    assign lut3 = {2'b01, 2'b11, 2'b01, 2'b10, 2'b10, 2'b01};

    // Degenerate single-entry table.
    logic        key1;
    logic [1:0]  lut1;
    logic        out1;
    logic        hit1;
    logic        out_q1;
    logic        hit_q1;

    assign lut1 = {1'b1, 1'b1};

    mux_key #(.NR_KEY(7), .KEY_LEN(3), .DATA_LEN(2)) u_dut7 (
        .clk(clk), .rst_n(rst_n), .key(key7), .lut(lut7),
        .out(out7), .hit(hit7), .out_q(out_q7), .hit_q(hit_q7)
    );

    mux_key #(.NR_KEY(3), .KEY_LEN(2), .DATA_LEN(2)) u_dut3 (
        .clk(clk), .rst_n(rst_n), .key(key3), .lut(lut3),
        .out(out3), .hit(hit3), .out_q(out_q3), .hit_q(hit_q3)
    );

    mux_key #(.NR_KEY(1), .KEY_LEN(1), .DATA_LEN(1)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .key(key1), .lut(lut1),
        .out(out1), .hit(hit1), .out_q(out_q1), .hit_q(hit_q1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string      tag;
        logic [7:0] exp;
    } sb_item_t;

    sb_item_t sb[$];
    int       checks;
    int       errors;

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h", tag, obs, exp);
        end else begin
            $display("ok   %s = %0h", tag, obs);
        end
    endtask

    task automatic sb_push(input string tag, input logic [7:0] exp);
        sb_item_t item;
        item.tag = tag;
        item.exp = exp;
        sb.push_back(item);
    endtask

    task automatic sb_check(input logic [7:0] obs);
        sb_item_t item;
        if (sb.size() == 0) begin
            chk("scoreboard_empty", obs, 8'hxx);
        end else begin
            item = sb.pop_front();
            chk(item.tag, obs, item.exp);
        end
    endtask

    // Expected decode of the 7-entry table with zc = lc = 10.
    logic [1:0] exp7 [8];

    initial begin
        exp7[0] = 2'b00; exp7[1] = 2'b10; exp7[2] = 2'b11; exp7[3] = 2'b00;
        exp7[4] = 2'b10; exp7[5] = 2'b10; exp7[6] = 2'b10; exp7[7] = 2'b10;

        checks = 0;
        errors = 0;
        rst_n  = 1'b0;
        key7   = 3'b000;
        zc     = 2'b10;
        lc     = 2'b10;
        key3   = 2'b00;
        key1   = 1'b0;

        // Reset state of the registered outputs.
        #1;
        sb_push("rst_out_q7", 8'h00); sb_push("rst_hit_q7", 8'h00);
        sb_push("rst_out_q3", 8'h00); sb_push("rst_out_q1", 8'h00);
        sb_check({6'd0, out_q7}); sb_check({7'd0, hit_q7});
        sb_check({6'd0, out_q3}); sb_check({7'd0, out_q1});

        @(negedge clk);
        rst_n = 1'b1;

        // Exhaustive decode.
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            key7 = k[2:0];
            sb_push($sformatf("dec_out_k%0d", k), {6'd0, exp7[k]});
            sb_push($sformatf("dec_hit_k%0d", k), (k == 3) ? 8'h00 : 8'h01);
            #1;
            sb_check({6'd0, out7});
            sb_check({7'd0, hit7});
        end

        // Live table data: no clock between the change and the check.
        @(negedge clk);
        key7 = 3'b100;
        #1;
        zc = 2'b00;
        sb_push("live_out", 8'h00); sb_push("live_hit", 8'h01);
        #1;
        sb_check({6'd0, out7}); sb_check({7'd0, hit7});
        zc = 2'b10;
        lc = 2'b01;
        key7 = 3'b110;
        sb_push("live_lc_out", 8'h01);
        #1;
        sb_check({6'd0, out7});
        lc = 2'b10;

        // Duplicate keys: first entry wins.
        begin
            logic [1:0] dk [4];
            logic [1:0] dexp [4];
            dk[0] = 2'b01; dexp[0] = 2'b11;
            dk[1] = 2'b00; dexp[1] = 2'b00;
            dk[2] = 2'b10; dexp[2] = 2'b01;
            dk[3] = 2'b11; dexp[3] = 2'b00;
            for (int i = 0; i < 4; i++) begin
                key3 = dk[i];
                sb_push($sformatf("dup_out_k%0d", dk[i]), {6'd0, dexp[i]});
                sb_push($sformatf("dup_hit_k%0d", dk[i]), (dk[i] == 2'b01 || dk[i] == 2'b10) ? 8'h01 : 8'h00);
                #1;
                sb_check({6'd0, out3});
                sb_check({7'd0, hit3});
            end
        end

        // Degenerate single-entry table.
        for (int i = 1; i >= 0; i--) begin
            key1 = i[0];
            sb_push($sformatf("deg_out_k%0d", i), i[7:0]);
            sb_push($sformatf("deg_hit_k%0d", i), i[7:0]);
            #1;
            sb_check({7'd0, out1});
            sb_check({7'd0, hit1});
        end

        // Registered path: known miss, then hit appears only after the edge.
        @(negedge clk);
        key7 = 3'b011;
        @(posedge clk); #1;
        sb_push("reg_miss_out_q", 8'h00); sb_push("reg_miss_hit_q", 8'h00);
        sb_check({6'd0, out_q7}); sb_check({7'd0, hit_q7});
        @(negedge clk);
        key7 = 3'b010;
        #1;
        sb_push("reg_before_out_q", 8'h00); sb_push("reg_before_hit_q", 8'h00);
        sb_check({6'd0, out_q7}); sb_check({7'd0, hit_q7});
        @(posedge clk); #1;
        sb_push("reg_after_out_q", 8'h03); sb_push("reg_after_hit_q", 8'h01);
        sb_check({6'd0, out_q7}); sb_check({7'd0, hit_q7});
        @(negedge clk);
        key7 = 3'b011;
        @(posedge clk); #1;
        sb_push("reg_clear_out_q", 8'h00); sb_push("reg_clear_hit_q", 8'h00);
        sb_check({6'd0, out_q7}); sb_check({7'd0, hit_q7});

        // Asynchronous reset between edges.
        @(negedge clk);
        key7 = 3'b010;
        @(posedge clk); #1;
        sb_push("pre_rst_out_q", 8'h03);
        sb_check({6'd0, out_q7});
        #1;
        rst_n = 1'b0;
        #1;
        sb_push("arst_out_q", 8'h00); sb_push("arst_hit_q", 8'h00); sb_push("arst_out", 8'h03);
        sb_check({6'd0, out_q7}); sb_check({7'd0, hit_q7}); sb_check({6'd0, out7});
        @(posedge clk); #1;
        sb_push("rst_hold_out_q", 8'h00);
        sb_check({6'd0, out_q7});
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        sb_push("rel_before_out_q", 8'h00);
        sb_check({6'd0, out_q7});
        @(posedge clk); #1;
        sb_push("rel_after_out_q", 8'h03); sb_push("rel_after_hit_q", 8'h01);
        sb_check({6'd0, out_q7}); sb_check({7'd0, hit_q7});

        if (sb.size() != 0) begin
            chk("scoreboard_leftover", sb.size(), 8'h00);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
